// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// pipelined_adder : segmented carry-pipelined adder/subtractor with
//                   valid/ready handshake; optional PIPE_ADDER_OVF_EN adds ovf.
// Revision: 1.0
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NSEG = WIDTH / SEG_W;

    logic             r_v [NSEG];
    logic             r_c [NSEG];
    logic [WIDTH-1:0] r_a [NSEG];
    logic [WIDTH-1:0] r_b [NSEG];
    logic [WIDTH-1:0] r_s [NSEG];
    logic             w_adv;
    logic [WIDTH-1:0] w_beff;
    logic             w_ceff;

    assign w_beff   = sub ? ~b : b;
    assign w_ceff   = sub | cin;
    assign w_adv    = !r_v[NSEG-1] || out_ready;
    assign in_ready = w_adv;

`ifdef PIPE_ADDER_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;
`endif

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO = k * SEG_W;

        logic             w_v_src;
        logic             w_c_src;
        logic [WIDTH-1:0] w_a_src;
        logic [WIDTH-1:0] w_b_src;
        logic [WIDTH-1:0] w_s_src;
        logic [WIDTH-1:0] w_seg;
        logic [SEG_W:0]   w_add;

        if (k == 0) begin : g_head
            assign w_v_src = in_valid;
            assign w_c_src = w_ceff;
            assign w_a_src = a;
            assign w_b_src = w_beff;
            assign w_s_src = '0;
        end else begin : g_body
            assign w_v_src = r_v[k-1];
            assign w_c_src = r_c[k-1];
            assign w_a_src = r_a[k-1];
            assign w_b_src = r_b[k-1];
            assign w_s_src = r_s[k-1];
        end

        assign w_add = {1'b0, w_a_src[LO +: SEG_W]} + {1'b0, w_b_src[LO +: SEG_W]}
                     + {{SEG_W{1'b0}}, w_c_src};
        // Segments at and above LO are still zero in the incoming partial sum.
        assign w_seg = WIDTH'(w_add[SEG_W-1:0]) << LO;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v[k] <= 1'b0;
                r_c[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end else if (w_adv) begin
                r_v[k] <= w_v_src;
                r_c[k] <= w_add[SEG_W];
                r_a[k] <= w_a_src;
                r_b[k] <= w_b_src;
                r_s[k] <= w_s_src | w_seg;
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        if (k == NSEG - 1) begin : g_ovf
            logic w_ovf;
            assign w_ovf = (w_a_src[WIDTH-1] == w_b_src[WIDTH-1])
                        && (w_add[SEG_W-1] != w_a_src[WIDTH-1]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_ovf;
                end
            end
        end
`endif
    end

    assign out_valid = r_v[NSEG-1];
    assign sum       = r_s[NSEG-1];
    assign cout      = r_c[NSEG-1];

endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and sum width in bits; legal range 8..64.
REQ-002 Parameter SEG_W, default 8, bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG_W. NSEG = WIDTH/SEG_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set on a, b, cin, sub is valid.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, used when sub=0.
REQ-010 sub  input  1  1: compute a - b; 0: compute a + b + cin.
REQ-011 out_valid  output  1  sum, cout and ovf hold a valid result.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
REQ-015 ovf  output  1  signed two's-complement overflow; present only with PIPE_ADDER_OVF_EN.

Function
REQ-016 Transfer in on the cycle in_valid=1 and in_ready=1; transfer out on out_valid=1 and out_ready=1.
REQ-017 Pipeline of NSEG register stages; stage k adds segment k (bits k*SEG_W..(k+1)*SEG_W-1) using the carry registered by stage k-1; stage 0 uses the effective carry-in.
REQ-018 Effective operands: sub=0 -> b, cin; sub=1 -> ~b, carry-in 1; cin ignored when sub=1.
REQ-019 Upper operand segments and already-computed lower sum segments are carried forward in per-stage registers alongside each stage's valid bit.
REQ-020 advance = !out_valid || out_ready; all stages shift one position when advance=1 and hold otherwise; in_ready = advance.
REQ-021 Stages holding bubbles (valid=0) shift like data; bubble contents are don't-care and never raise out_valid.
REQ-022 Latency: result appears with out_valid=1 exactly NSEG cycles after acceptance when out_ready stays 1.
REQ-023 Throughput: one operand set per cycle sustained while out_ready=1.
REQ-024 Stall: with out_valid=1 and out_ready=0, sum/cout/ovf/out_valid hold stable and no input is accepted; no result is dropped or duplicated.
REQ-025 Simultaneous output transfer and input transfer in the same cycle SHALL both complete.
REQ-026 Results emerge in acceptance order.

Reset
REQ-027 rst_n=0 SHALL immediately clear every stage valid bit, out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 while in reset and afterwards until first stall.
REQ-028 Reset mid-operation discards all in-flight operands; no result for them is ever emitted.
REQ-029 Deassertion of rst_n is synchronised externally; the first operand may be accepted on the first rising edge after release.

Configuration
REQ-030 Macro PIPE_ADDER_OVF_EN defined: ovf port exists; ovf = (a[MSB]==beff[MSB]) && (sum[MSB]!=a[MSB]), using effective B, pipelined with its result.
REQ-031 PIPE_ADDER_OVF_EN undefined: ovf port and its sign-tracking registers are absent; all other behaviour identical.

Verification
REQ-032 WIDTH=32,SEG_W=8: a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0 -> after 4 cycles sum=0x00000000, cout=1 (carry ripples across all segments).
REQ-033 Subtract: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0; with OVF_EN, a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
REQ-034 Back-to-back: 16 random operand sets on consecutive cycles, out_ready=1 -> 16 correct results on 16 consecutive cycles starting cycle 4, in order.
REQ-035 Backpressure: out_ready=0 for 5 cycles while results pending -> in_ready=0, outputs stable; on release all results delivered once, in order.
REQ-036 Reset with 3 operand sets in flight -> out_valid=0 immediately; none of those results ever appears after release.
REQ-037 WIDTH=8,SEG_W=8 (NSEG=1): a=0x6A, b=0xDB, cin=0 -> sum=0x45, cout=1 after 1 cycle.
